// File: rtl/pc_defs.sv
// Shared definitions for the fetch-stage PC sequencer.
// PCSEL encodings of resolving control instructions, FSM states.
package pc_defs;

  localparam logic [1:0] PCSEL_PCPLUSFOUR = 2'b00;
  localparam logic [1:0] PCSEL_PCOFFSET   = 2'b01;
  localparam logic [1:0] PCSEL_REGOFFSET  = 2'b10;
  localparam logic [1:0] PCSEL_RESERVED   = 2'b11;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target calculation for EX-resolved control instructions.
// In: brSel, brCmp, brPc, brImm, brReg. Out: taken, target, misaligned.
module pc_target_calc
  import pc_defs::*;
#(
  parameter int DBITS      = 32,
  parameter int INSN_BYTES = 4,
  parameter int IMM_SHIFT  = 2
) (
  input  logic [1:0]       brSel,
  input  logic             brCmp,
  input  logic [DBITS-1:0] brPc,
  input  logic [DBITS-1:0] brImm,
  input  logic [DBITS-1:0] brReg,
  output logic             taken,
  output logic [DBITS-1:0] target,
  output logic             misaligned
);

  localparam logic [DBITS-1:0] W_STEP =
    DBITS'(INSN_BYTES);
  localparam logic [DBITS-1:0] W_MASK =
    DBITS'(INSN_BYTES - 1);

  logic [DBITS-1:0] w_off;

  assign w_off = brImm << IMM_SHIFT;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    unique case (brSel)
      PCSEL_PCOFFSET: begin
        taken  = brCmp;
        target = brPc + W_STEP + w_off;
      end
      PCSEL_REGOFFSET: begin
        taken  = 1'b1;
        target = brReg + w_off;
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  assign misaligned = taken & (|(target & W_MASK));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC generator with redirect, flush and redirect counter.
// Ports: fetch handshake, stall, EX redirect inputs, pulses, count.
module pc_sequencer
  import pc_defs::*;
#(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] START_PC   = 64,
  parameter int               INSN_BYTES = 4,
  parameter int               IMM_SHIFT  = 2,
  parameter logic [DBITS-1:0] EXC_VECTOR = 256,
  parameter int               CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                fetchValid,
  output logic [DBITS-1:0]    fetchPc,
  input  logic                fetchReady,
  input  logic                stall,
  input  logic                brValid,
  input  logic [1:0]          brSel,
  input  logic                brCmp,
  input  logic [DBITS-1:0]    brPc,
  input  logic [DBITS-1:0]    brImm,
  input  logic [DBITS-1:0]    brReg,
  input  logic                excValid,
  output logic                flushOut,
  output logic                misalignOut,
  output logic [CNT_BITS-1:0] redirectCount
);

  localparam logic [DBITS-1:0] W_STEP =
    DBITS'(INSN_BYTES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DBITS-1:0]    r_pc;
  logic [DBITS-1:0]    w_pc_nxt;
  logic                r_flush;
  logic                r_mis;
  logic [CNT_BITS-1:0] r_cnt;

  logic             w_taken;
  logic             w_mis;
  logic [DBITS-1:0] w_target;
  logic             w_br_mis;
  logic             w_exc;
  logic             w_br;
  logic             w_redirect;
  logic             w_xfer;

  pc_target_calc #(
    .DBITS      (DBITS),
    .INSN_BYTES (INSN_BYTES),
    .IMM_SHIFT  (IMM_SHIFT)
  ) u_calc (
    .brSel      (brSel),
    .brCmp      (brCmp),
    .brPc       (brPc),
    .brImm      (brImm),
    .brReg      (brReg),
    .taken      (w_taken),
    .target     (w_target),
    .misaligned (w_mis)
  );

  // A misaligned taken target is folded into the exception path.
  assign w_br_mis   = brValid & w_taken & w_mis;
  assign w_exc      = excValid | w_br_mis;
  assign w_br       = brValid & w_taken & ~w_mis;
  assign w_redirect = w_exc | w_br;
  assign w_xfer     = (r_state == ST_RUN)
                    & fetchReady & ~stall;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Overlapping conditions: an ordered chain gives priority.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_exc)       w_pc_nxt = EXC_VECTOR;
    else if (w_br)   w_pc_nxt = w_target;
    else if (w_xfer) w_pc_nxt = r_pc + W_STEP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
      r_pc    <= START_PC;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_redirect;
      r_mis   <= w_br_mis;
      if (w_redirect && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign fetchValid    = (r_state == ST_RUN);
  assign fetchPc       = r_pc;
  assign flushOut      = r_flush;
  assign misalignOut   = r_mis;
  assign redirectCount = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table + scoreboard.
// Second instance with CNT_BITS=2 checks counter saturation.
module tb_pc_sequencer;
  import pc_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReady, stall;
  logic        brValid, brCmp, excValid;
  logic [1:0]  brSel;
  logic [31:0] brPc, brImm, brReg;

  logic        fv, fl, ms;
  logic [31:0] pc;
  logic [15:0] cnt;
  logic        fv2, fl2, ms2;
  logic [31:0] pc2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset),
    .fetchValid(fv), .fetchPc(pc),
    .fetchReady(fetchReady), .stall(stall),
    .brValid(brValid), .brSel(brSel),
    .brCmp(brCmp), .brPc(brPc),
    .brImm(brImm), .brReg(brReg),
    .excValid(excValid), .flushOut(fl),
    .misalignOut(ms), .redirectCount(cnt)
  );

  pc_sequencer #(.CNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset),
    .fetchValid(fv2), .fetchPc(pc2),
    .fetchReady(fetchReady), .stall(stall),
    .brValid(brValid), .brSel(brSel),
    .brCmp(brCmp), .brPc(brPc),
    .brImm(brImm), .brReg(brReg),
    .excValid(excValid), .flushOut(fl2),
    .misalignOut(ms2), .redirectCount(cnt2)
  );

  typedef struct {
    string       name;
    logic        rdy, stl, bv, cmp, exc;
    logic [1:0]  sel;
    logic [31:0] bpc, imm, reg_;
    logic [31:0] e_pc;
    logic        e_v, e_fl, e_ms;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v, fl, ms;
    logic [15:0] cnt;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    string n, logic rdy, logic stl, logic bv,
    logic [1:0] sel, logic cmp,
    logic [31:0] bpc, logic [31:0] imm,
    logic [31:0] r, logic exc,
    logic [31:0] e_pc, logic e_fl,
    logic e_ms, logic [15:0] e_cnt);
    vec_t v;
    v.name = n; v.rdy = rdy; v.stl = stl;
    v.bv = bv; v.sel = sel; v.cmp = cmp;
    v.bpc = bpc; v.imm = imm; v.reg_ = r;
    v.exc = exc; v.e_pc = e_pc; v.e_v = 1'b1;
    v.e_fl = e_fl; v.e_ms = e_ms;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               n, act, exp);
    end
  endtask

  task automatic idle();
    brValid = 0; brSel = PCSEL_PCPLUSFOUR;
    brCmp = 0; brPc = 0; brImm = 0; brReg = 0;
    excValid = 0;
  endtask

  task automatic check_reset(string n);
    chk({n, ".pc"}, pc, 32'h40);
    chk({n, ".valid"}, 32'(fv), 0);
    chk({n, ".flush"}, 32'(fl), 0);
    chk({n, ".mis"}, 32'(ms), 0);
    chk({n, ".cnt"}, 32'(cnt), 0);
    chk({n, ".cnt2"}, 32'(cnt2), 0);
  endtask

  task automatic check_out(exp_t e);
    logic [15:0] c2;
    c2 = (e.cnt > 3) ? 16'd3 : e.cnt;
    chk({e.name, ".pc"}, pc, e.pc);
    chk({e.name, ".valid"}, 32'(fv), 32'(e.v));
    chk({e.name, ".flush"}, 32'(fl), 32'(e.fl));
    chk({e.name, ".mis"}, 32'(ms), 32'(e.ms));
    chk({e.name, ".cnt"}, 32'(cnt), 32'(e.cnt));
    chk({e.name, ".pc2"}, pc2, e.pc);
    chk({e.name, ".cnt2"}, 32'(cnt2), 32'(c2));
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    fetchReady = v.rdy; stall = v.stl;
    brValid = v.bv; brSel = v.sel;
    brCmp = v.cmp; brPc = v.bpc;
    brImm = v.imm; brReg = v.reg_;
    excValid = v.exc;
    e.name = v.name; e.pc = v.e_pc; e.v = v.e_v;
    e.fl = v.e_fl; e.ms = v.e_ms; e.cnt = v.e_cnt;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check_out(exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    localparam logic [1:0] P4 = PCSEL_PCPLUSFOUR;
    localparam logic [1:0] PO = PCSEL_PCOFFSET;
    localparam logic [1:0] RO = PCSEL_REGOFFSET;
    localparam logic [1:0] RS = PCSEL_RESERVED;
    vec_t v;

    vt.push_back(mk("boot", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h40, 0,0, 0));
    vt.push_back(mk("seq1", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h44, 0,0, 0));
    vt.push_back(mk("seq2", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h48, 0,0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk("nordy", 0,0, 0,P4,0, 0,0,0, 0,
                      32'h48, 0,0, 0));
    vt.push_back(mk("rdyback", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h4C, 0,0, 0));
    vt.push_back(mk("bt", 1,0, 1,PO,1, 32'h50,4,0, 0,
                    32'h64, 1,0, 1));
    vt.push_back(mk("bt_after", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h68, 0,0, 1));
    vt.push_back(mk("bnt", 1,0, 1,PO,0, 32'h50,4,0, 0,
                    32'h6C, 0,0, 1));
    vt.push_back(mk("jr_stall", 0,1, 1,RO,0, 0,4,32'h50,
                    0, 32'h60, 1,0, 2));
    vt.push_back(mk("stall_hold", 1,1, 0,P4,0, 0,0,0, 0,
                    32'h60, 0,0, 2));
    vt.push_back(mk("jr_mis", 1,0, 1,RO,0, 0,0,32'h51,
                    0, 32'h100, 1,1, 3));
    vt.push_back(mk("mis_after", 1,0, 0,P4,0, 0,0,0, 0,
                    32'h104, 0,0, 3));
    vt.push_back(mk("exc_br", 1,0, 1,PO,1, 0,4,0, 1,
                    32'h100, 1,0, 4));
    vt.push_back(mk("wrap", 1,0, 1,PO,1, 32'hFFFFFFF8,
                    1,0, 0, 32'h0, 1,0, 5));
    vt.push_back(mk("rsvd", 1,0, 1,RS,1, 32'h80,4,
                    32'h80, 0, 32'h4, 0,0, 5));
    vt.push_back(mk("exc_stall", 0,1, 0,P4,0, 0,0,0, 1,
                    32'h100, 1,0, 6));

    reset = 0; fetchReady = 1; stall = 0; idle();
    @(posedge clk); @(posedge clk); #1;
    check_reset("reset");
    reset = 1;
    foreach (vt[i]) apply(vt[i]);

    // async reset mid-stream; pending redirect dropped
    idle(); fetchReady = 1;
    brValid = 1; brSel = RO; brReg = 32'h300;
    @(negedge clk);
    reset = 0;
    #1 check_reset("async_rst");
    @(posedge clk); #1;
    check_reset("rst_held");

    // redirect captured while leaving BOOT
    reset = 1;
    v = mk("boot_redir", 1,0, 1,RO,0, 0,0,32'h200, 0,
           32'h200, 1,0, 1);
    apply(v);
    v = mk("boot_after", 1,0, 0,P4,0, 0,0,0, 0,
           32'h204, 0,0, 1);
    apply(v);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: got %0d left want 0",
               exp_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
